apb_slave_array: RTL and testbench

Parametrised APB completer model sitting on the peripheral side of the AHB-to-APB bridge. It replaces the pass-through interface with NUM_SLAVES real word-addressed register banks. It adds programmable wait states through Pready and error signalling through Pslverr. Read data comes from storage written by earlier transfers, so the bridge can be verified end to end with data checking.

---
 rtl/apb_slave_array.sv | 108 ++++++++++
 tb/tb_apb_slave_array.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_array.sv
// APB completer with NUM_SLAVES word-addressed register banks. Adds programmable wait
// states through Pready and flags illegal transfers through Pslverr.
module apb_slave_array #(
    parameter int NUM_SLAVES  = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [ADDR_WIDTH-1:0] Paddr,
    input  logic [DATA_WIDTH-1:0] Pwdata,
    output logic [DATA_WIDTH-1:0] Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);
    // state  | meaning
    // IDLE   | no transfer; waiting for a select with Penable low
    // SETUP  | transfer recognised; legality is sampled on the way out
    // ACCESS | wait counter runs down; Pready high once it reaches zero

    localparam int IW = $clog2(DEPTH);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   mem [NUM_SLAVES][DEPTH];
    logic [SW-1:0]           sel_idx;
    logic [IW-1:0]           word;
    logic                    legal;
    logic                    any_sel;

    always_comb begin
        sel_idx = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (Pselx[s]) sel_idx = s[SW-1:0];
        end
    end

    assign word    = Paddr[IW+1:2];
    assign any_sel = |Pselx;
    assign legal   = $onehot(Pselx) && (Paddr[1:0] == 2'b00) &&
                     (Paddr[ADDR_WIDTH-1:IW+2] == '0);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state   <= IDLE;
            cnt     <= '0;
            illegal <= 1'b0;
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem[s][w] <= '0;
                end
            end
        end else begin
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_sel && !Penable) state <= SETUP;
                end
                SETUP: begin
                    if (!any_sel) begin
                        state <= IDLE;
                    end else begin
                        state   <= ACCESS;
                        cnt     <= 4'(WAIT_STATES);
                        illegal <= !legal;
                        if (WAIT_STATES == 0) begin
                            Pready  <= 1'b1;
                            Pslverr <= !legal;
                        end
                    end
                end
                ACCESS: begin
                    if (!any_sel) begin
                        // deselect aborts: nothing committed, Pready stays low
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            Pready  <= 1'b1;
                            Pslverr <= illegal;
                        end
                    end else begin
                        if (!illegal && Pwrite) mem[sel_idx][word] <= Pwdata;
                        state <= (any_sel && !Penable) ? SETUP : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pready/Pslverr are registered, so Prdata is qualified by already-stable flags
    assign Prdata = (Pready && !Pslverr && !Pwrite) ? mem[sel_idx][word] : '0;

endmodule

// File: tb/tb_apb_slave_array.sv
// Bench for apb_slave_array: three instances (0, 2, 3 wait states) driven by directed
// transfers; a transfer-level model predicts Pready/Pslverr/Prdata every cycle.
module tb_apb_slave_array;
    localparam int NI = 3;
    localparam int NS = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 16;

    logic           clk;
    logic           rstn    [NI];
    logic [NS-1:0]  psel    [NI];
    logic           pen     [NI];
    logic           pwr     [NI];
    logic [AW-1:0]  paddr   [NI];
    logic [DW-1:0]  pwdata  [NI];
    logic [DW-1:0]  prdata  [NI];
    logic           pready  [NI];
    logic           pslverr [NI];

    logic           exp_ready [NI];
    logic           exp_err   [NI];
    logic [DW-1:0]  exp_rdata [NI];
    logic [DW-1:0]  mem [NI][NS][DEPTH];

    int total = 0;
    int bad   = 0;

    int            xl;
    logic [DW-1:0] xr;
    logic          xe;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            apb_slave_array #(
                .NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
            ) u_dut (
                .Hclk(clk), .Hresetn(rstn[g]), .Pselx(psel[g]), .Penable(pen[g]),
                .Pwrite(pwr[g]), .Paddr(paddr[g]), .Pwdata(pwdata[g]),
                .Prdata(prdata[g]), .Pready(pready[g]), .Pslverr(pslverr[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("pready[%0d]", i),  32'(pready[i]),  32'(exp_ready[i]));
            chk($sformatf("pslverr[%0d]", i), 32'(pslverr[i]), 32'(exp_err[i]));
            chk($sformatf("prdata[%0d]", i),  prdata[i],       exp_rdata[i]);
        end
    end

    task automatic idle_exp(input int i);
        exp_ready[i] = 1'b0;
        exp_err[i]   = 1'b0;
        exp_rdata[i] = '0;
    endtask

    task automatic clear_model(input int i);
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < DEPTH; w++) mem[i][s][w] = '0;
    endtask

    task automatic sample(input int i, input int c);
        if (xl < 0 && pready[i] === 1'b1) begin
            xl = c;
            xr = prdata[i];
            xe = pslverr[i];
        end
    endtask

    task automatic drive(input int i, input logic [2:0] sel, input logic [31:0] a,
                         input logic wr, input logic [31:0] wd, input logic en);
        psel[i] = sel; paddr[i] = a; pwr[i] = wr; pwdata[i] = wd; pen[i] = en;
    endtask

    // One transfer; results in xl (ready cycle, counting FSM SETUP as 1), xr, xe.
    task automatic xfer(input int i, input logic [2:0] sel, input logic [31:0] a,
                        input logic wr, input logic [31:0] wd,
                        input bit chained, input bit next_chained);
        bit ok;
        int b, w, c;
        ok = ($countones(sel) == 1) && (a % 4 == 0) && (a < 4 * DEPTH);
        b = 0; w = 0;
        if (ok) begin
            b = $clog2(sel);
            w = int'(a / 4);
        end
        xl = -1; xr = '0; xe = 1'b0;
        if (!chained) begin
            drive(i, sel, a, wr, wd, 1'b0);
            idle_exp(i);
            @(posedge clk); #1;
        end
        drive(i, sel, a, wr, wd, 1'b1);
        idle_exp(i);
        c = 1;
        #1 sample(i, c);
        for (int k = 0; k < ws_of(i); k++) begin
            @(posedge clk); #1;
            c++;
            #1 sample(i, c);
        end
        @(posedge clk); #1;
        c++;
        exp_ready[i] = 1'b1;
        exp_err[i]   = !ok;
        exp_rdata[i] = (ok && !wr) ? mem[i][b][w] : '0;
        if (next_chained) pen[i] = 1'b0;
        #1 sample(i, c);
        @(posedge clk); #1;
        if (ok && wr) mem[i][b][w] = wd;
        idle_exp(i);
        if (!next_chained) begin
            psel[i] = '0;
            pen[i]  = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rstn[i] = 1'b0;
            drive(i, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0);
            idle_exp(i);
            clear_model(i);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rstn[i] = 1'b1;

        // instance 0, no wait states
        xfer(0, 3'b001, 32'h0, 1'b0, 32'h0, 0, 0);
        chk("rst_read_lat", 32'(xl), 32'd2);
        chk("rst_read_data", xr, 32'h0);
        chk("rst_read_err", 32'(xe), 32'h0);

        xfer(0, 3'b010, 32'h3C, 1'b1, 32'hDEADBEEF, 0, 0);
        xfer(0, 3'b010, 32'h3C, 1'b0, 32'h0, 0, 0);
        chk("rd_deadbeef", xr, 32'hDEADBEEF);
        xfer(0, 3'b010, 32'h38, 1'b0, 32'h0, 0, 0);
        chk("rd_b1w14", xr, 32'h0);
        xfer(0, 3'b100, 32'h3C, 1'b0, 32'h0, 0, 0);
        chk("rd_b2w15", xr, 32'h0);

        for (int s = 0; s < NS; s++)
            xfer(0, 3'(1 << s), 32'h0, 1'b1, 32'h11110000 + 32'(s), 0, 0);

        xfer(0, 3'b010, 32'h40, 1'b1, 32'hFFFFFFFF, 0, 0);
        chk("err_range", 32'(xe), 32'h1);
        xfer(0, 3'b010, 32'h02, 1'b1, 32'hFFFFFFFF, 0, 0);
        chk("err_align", 32'(xe), 32'h1);
        xfer(0, 3'b011, 32'h00, 1'b1, 32'hFFFFFFFF, 0, 0);
        chk("err_sel", 32'(xe), 32'h1);
        xfer(0, 3'b001, 32'h40, 1'b0, 32'h0, 0, 0);
        chk("err_rd_data", xr, 32'h0);

        for (int s = 0; s < NS; s++) begin
            xfer(0, 3'(1 << s), 32'h0, 1'b0, 32'h0, 0, 0);
            chk($sformatf("word0_b%0d", s), xr, 32'h11110000 + 32'(s));
        end

        xfer(0, 3'b100, 32'h14, 1'b1, 32'h12345678, 0, 1);
        xfer(0, 3'b100, 32'h14, 1'b0, 32'h0, 1, 0);
        chk("b2b_data", xr, 32'h12345678);
        chk("b2b_lat", 32'(xl), 32'd2);

        // reset asserted inside a read's Pready cycle
        drive(0, 3'b010, 32'h3C, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        pen[0] = 1'b1;
        @(posedge clk); #1;
        exp_ready[0] = 1'b1;
        exp_rdata[0] = mem[0][1][15];
        #1;
        chk("pre_rst_ready", 32'(pready[0]), 32'h1);
        chk("pre_rst_data", prdata[0], 32'hDEADBEEF);
        #1;
        rstn[0] = 1'b0;
        idle_exp(0);
        clear_model(0);
        #1;
        chk("async_rst_ready", 32'(pready[0]), 32'h0);
        chk("async_rst_data", prdata[0], 32'h0);
        @(posedge clk); #1;
        drive(0, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        rstn[0] = 1'b1;
        xfer(0, 3'b010, 32'h3C, 1'b0, 32'h0, 0, 0);
        chk("post_rst_b1w15", xr, 32'h0);

        // instance 2, three wait states
        xfer(2, 3'b001, 32'h0, 1'b0, 32'h0, 0, 0);
        chk("ws3_lat", 32'(xl), 32'd5);
        xfer(2, 3'b001, 32'h4, 1'b1, 32'hCAFEF00D, 0, 0);
        xfer(2, 3'b001, 32'h4, 1'b0, 32'h0, 0, 0);
        chk("ws3_rd", xr, 32'hCAFEF00D);

        // instance 1, two wait states, reset in the first wait cycle of a write
        xfer(1, 3'b001, 32'h8, 1'b1, 32'h5A5A5A5A, 0, 0);
        xfer(1, 3'b001, 32'h8, 1'b0, 32'h0, 0, 0);
        chk("ws2_rd", xr, 32'h5A5A5A5A);
        chk("ws2_lat", 32'(xl), 32'd4);
        drive(1, 3'b001, 32'hC, 1'b1, 32'hA5A5A5A5, 1'b0);
        @(posedge clk); #1;
        pen[1] = 1'b1;
        @(posedge clk); #1;
        #2;
        rstn[1] = 1'b0;
        idle_exp(1);
        clear_model(1);
        #1;
        chk("mid_rst_ready", 32'(pready[1]), 32'h0);
        chk("mid_rst_err", 32'(pslverr[1]), 32'h0);
        chk("mid_rst_data", prdata[1], 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rstn[1] = 1'b1;
        drive(1, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(1, 3'b001, 32'hC, 1'b0, 32'h0, 0, 0);
        chk("mid_rst_word", xr, 32'h0);
        chk("mid_rst_word_lat", 32'(xl), 32'd4);
        xfer(1, 3'b001, 32'h8, 1'b0, 32'h0, 0, 0);
        chk("mid_rst_cleared", xr, 32'h0);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
